// File: rtl/stonet_hidden_neuron_p.sv
// Hidden neuron for the stochastic-spiking network: pipelined saturating
// adder tree feeding a membrane accumulator, one spike per block, feedback
// error/true accumulation and a delay line of trained membrane values.
module stonet_hidden_neuron_p #(
  parameter int              NIN      = 4,
  parameter int              WW       = 9,
  parameter int              AW       = 10,
  parameter int              NOUT     = 10,
  parameter int              FW       = 7,
  parameter logic [NOUT*FW-1:0] FB_INIT = '0,
  parameter int              FP_DEPTH = 4,
  parameter int              TH       = 160,
  parameter int              SLOPE    = 205,
  parameter logic [15:0]     SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NIN*WW-1:0]   weights,
  input  logic                w_valid,
  input  logic                new_block,
  input  logic                gen_spike,
  input  logic                train,
  input  logic [3:0]          outaddr,
  input  logic                errspikes,
  input  logic                truespikes,
  input  logic                fb_we,
  input  logic [3:0]          fb_waddr,
  input  logic [FW-1:0]       fb_wdata,
  output logic                spike,
  output logic [AW-1:0]       fp,
  output logic [AW-1:0]       err,
  output logic [AW-1:0]       true,
  output logic                fp_valid
);

  // Tree is stored heap-style: node 0 is the root, leaves are NIN-1..2*NIN-2.
  localparam int NN = 2*NIN - 1;
  localparam int CW = $clog2(FP_DEPTH + 1);
  localparam int PW = AW + 32;
  localparam logic [AW-1:0]        SMAX    = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0]        SMIN    = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [PW-1:0] SLOPE_S = PW'(SLOPE);
  localparam logic signed [PW-1:0] TH_S    = PW'(TH);
  localparam logic signed [PW-1:0] PHALF   = PW'(2**(AW-1));
  localparam logic signed [PW-1:0] PMAX    = PW'(2**AW - 1);
  localparam logic [CW-1:0]        CFULL   = CW'(FP_DEPTH);

  // Signed add clamped to the AW-bit range; overflow seen in the top two bits.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (s[AW] != s[AW-1]) return s[AW] ? SMIN : SMAX;
    return s[AW-1:0];
  endfunction

  logic [NIN-1:0][AW-1:0]      wext;
  logic [NN-1:0][AW-1:0]       node;
  logic [AW-1:0]               internal;
  logic [NOUT-1:0][FW-1:0]     fb;
  logic [AW-1:0]               fb_rd;
  logic [AW-1:0]               errsig, truesig;
  logic [15:0]                 lfsr;
  logic [AW-1:0]               rnd;
  logic signed [PW-1:0]        prod, pv;
  logic [AW-1:0]               p;
  logic                        spike_buf;
  logic [FP_DEPTH-1:0][AW-1:0] dline;
  logic [CW-1:0]               cnt;

  // Per-lane sign extension of the incoming weights to accumulator width.
  genvar g;
  for (g = 0; g < NIN; g++) begin : g_lane
    assign wext[g] = {{(AW-WW){weights[g*WW+WW-1]}}, weights[g*WW +: WW]};
  end

  // Input registers and tree levels; new_block flushes anything in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      node <= '0;
    end else if (new_block) begin
      node <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) node[NIN-1+i] <= w_valid ? wext[i] : '0;
      for (int i = 0; i < NIN-1; i++) node[i] <= sat_add(node[2*i+1], node[2*i+2]);
    end
  end

  // Membrane accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        internal <= '0;
    else if (new_block) internal <= '0;
    else                internal <= sat_add(internal, node[0]);
  end

  // Feedback read; out-of-range addresses contribute zero.
  always_comb begin
    fb_rd = '0;
    if (int'(outaddr) < NOUT) fb_rd = {{(AW-FW){fb[outaddr][FW-1]}}, fb[outaddr]};
  end

  // Feedback weight RAM; reads in the same cycle see the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fb <= FB_INIT;
    else if (fb_we && int'(fb_waddr) < NOUT) fb[fb_waddr] <= fb_wdata;
  end

  // Error / true feedback accumulators for the current block.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      errsig  <= '0;
      truesig <= '0;
    end else if (new_block) begin
      errsig  <= '0;
      truesig <= '0;
    end else begin
      if (errspikes)  errsig  <= sat_add(errsig, fb_rd);
      if (truespikes) truesig <= sat_add(truesig, fb_rd);
    end
  end

  // Sigmoid-approximate firing probability, evaluated at full product width.
  always_comb begin
    prod = $signed(internal) * SLOPE_S;
    pv   = (prod >>> 6) + PHALF;
    if ($signed(internal) > TH_S)       p = '1;
    else if ($signed(internal) < -TH_S) p = '0;
    else if (pv < 0)                    p = '0;
    else if (pv > PMAX)                 p = '1;
    else                                p = pv[AW-1:0];
  end

  assign rnd = lfsr[AW-1:0];

  // Fibonacci LFSR (taps 16,14,13,11) stepped once per spike evaluation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= SEED;
    else if (gen_spike && !new_block) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // Spike candidate: stochastic when training, sign test otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        spike_buf <= 1'b0;
    else if (new_block) spike_buf <= 1'b0;
    else if (gen_spike) spike_buf <= train ? (p > rnd) : ($signed(internal) > 0);
  end

  // Block-end publication; learning state only moves on trained blocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spike <= 1'b0;
      err   <= '0;
      true  <= '0;
      dline <= '0;
      cnt   <= '0;
    end else if (new_block) begin
      spike <= spike_buf;
      if (train) begin
        dline[0] <= internal;
        for (int i = 1; i < FP_DEPTH; i++) dline[i] <= dline[i-1];
        err  <= errsig;
        true <= truesig;
        if (cnt != CFULL) cnt <= cnt + CW'(1);
      end
    end
  end

  assign fp       = dline[FP_DEPTH-1];
  assign fp_valid = (cnt == CFULL);

endmodule

// File: tb/tb_stonet_hidden_neuron_p.sv
// Randomized bench for stonet_hidden_neuron_p against a block-level model.
module tb_stonet_hidden_neuron_p;
  localparam int NIN = 4, WW = 9, AW = 10, NOUT = 10, FW = 7, D = 4, TH = 160, SLOPE = 205;
  localparam int MAXV = 2**(AW-1) - 1, MINV = -(2**(AW-1));

  logic clk = 1'b0, resetn = 1'b1;
  logic [NIN*WW-1:0] weights = '0;
  logic w_valid = 0, new_block = 0, gen_spike = 0, train = 0;
  logic [3:0] outaddr = '0, fb_waddr = '0;
  logic errspikes = 0, truespikes = 0, fb_we = 0;
  logic [FW-1:0] fb_wdata = '0;
  logic spike, fp_valid;
  logic [AW-1:0] fp, err, true;

  stonet_hidden_neuron_p dut (
    .clk(clk), .resetn(resetn), .weights(weights), .w_valid(w_valid),
    .new_block(new_block), .gen_spike(gen_spike), .train(train),
    .outaddr(outaddr), .errspikes(errspikes), .truespikes(truespikes),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .spike(spike), .fp(fp), .err(err), .true(true), .fp_valid(fp_valid));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Block-level reference state ("eventual" membrane value, no pipeline).
  int m_int, m_errsig, m_truesig, m_err, m_true, m_lfsr, m_cnt;
  bit m_sbuf, m_spike;
  int m_fb[NOUT];
  int m_q[$];

  function automatic int clampw(int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic int prob(int x);
    int t, q, v;
    if (x > TH) return 2**AW - 1;
    if (x < -TH) return 0;
    t = x * SLOPE;
    q = (t >= 0) ? t / 64 : -((-t + 63) / 64);
    v = 2**(AW-1) + q;
    if (v < 0) return 0;
    if (v > 2**AW - 1) return 2**AW - 1;
    return v;
  endfunction

  function automatic int lfsr_next(int l);
    return (l >> 1) | ((((l) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
  endfunction

  task automatic model_reset();
    m_int = 0; m_errsig = 0; m_truesig = 0; m_err = 0; m_true = 0;
    m_lfsr = 16'hACE1; m_cnt = 0; m_sbuf = 0; m_spike = 0;
    foreach (m_fb[i]) m_fb[i] = 0;
    m_q.delete();
  endtask

  // One clock: drive inputs, advance the model, settle 1 ns past the edge.
  task automatic step(input bit wv, input int w0, input int w1, input int w2, input int w3,
                      input bit nb, input bit gs, input bit tr, input int oa,
                      input bit es, input bit ts, input bit we, input int wa, input int wd);
    int rv;
    w_valid = wv; weights = {w3[WW-1:0], w2[WW-1:0], w1[WW-1:0], w0[WW-1:0]};
    new_block = nb; gen_spike = gs; train = tr; outaddr = oa[3:0];
    errspikes = es; truespikes = ts; fb_we = we; fb_waddr = wa[3:0]; fb_wdata = wd[FW-1:0];
    @(posedge clk);
    rv = (oa < NOUT) ? m_fb[oa] : 0;
    if (nb) begin
      m_spike = m_sbuf;
      if (tr) begin
        m_q.push_back(m_int); m_err = m_errsig; m_true = m_truesig;
        if (m_cnt < D) m_cnt++;
      end
      m_int = 0; m_errsig = 0; m_truesig = 0; m_sbuf = 0;
    end else begin
      if (wv) m_int = clampw(m_int + clampw(clampw(w0 + w1) + clampw(w2 + w3)));
      if (es) m_errsig = clampw(m_errsig + rv);
      if (ts) m_truesig = clampw(m_truesig + rv);
      if (gs) begin
        m_sbuf = tr ? (prob(m_int) > (m_lfsr & (2**AW - 1))) : (m_int > 0);
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
    if (we && wa < NOUT) m_fb[wa] = wd;
    #1;
  endtask

  task automatic check_outs();
    chk("spike", spike, int'(m_spike));
    chk("fp", $signed(fp), (m_q.size() >= D) ? m_q[m_q.size() - D] : 0);
    chk("fp_valid", fp_valid, int'(m_cnt == D));
    chk("err", $signed(err), m_err);
    chk("true", $signed(true), m_true);
  endtask

  task automatic do_reset();
    #3;
    w_valid = 0; new_block = 0; gen_spike = 0; train = 0; errspikes = 0;
    truespikes = 0; fb_we = 0; weights = '0;
    resetn = 1'b0;
    #1;
    chk("rst_spike", spike, 0);
    chk("rst_fp", fp, 0);
    chk("rst_err", err, 0);
    chk("rst_true", true, 0);
    chk("rst_fp_valid", fp_valid, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // wmode: 0 all lanes = wc, 1 small random, 2 full random, 3 lane0 = wc only.
  task automatic blk(input int ncyc, input int wmode, input int wc, input bit tr,
                     input bit gen, input bit fbr);
    int w[4];
    bit wv;
    for (int c = 0; c < ncyc + 4 + 2; c++) begin
      bit es, ts, we;
      int oa, wa, wd;
      es = fbr && $urandom_range(0, 1); ts = fbr && $urandom_range(0, 1);
      we = fbr && ($urandom_range(0, 3) == 0);
      oa = $urandom_range(0, 15); wa = $urandom_range(0, 15);
      wd = int'($urandom_range(0, 127)) - 64;
      foreach (w[k]) w[k] = 0;
      wv = 0;
      if (c < ncyc) begin
        wv = 1;
        foreach (w[k]) begin
          case (wmode)
            0: w[k] = wc;
            1: w[k] = int'($urandom_range(0, 60)) - 30;
            2: w[k] = int'($urandom_range(0, 511)) - 256;
            default: w[k] = (k == 0) ? wc : 0;
          endcase
        end
        if (wmode == 1 || wmode == 2) wv = ($urandom_range(0, 3) != 0);
      end
      if (c == ncyc + 4) step(0, 0, 0, 0, 0, 0, gen, tr, oa, es, ts, we, wa, wd);
      else if (c == ncyc + 5) step(0, 0, 0, 0, 0, 1, 0, tr, oa, es, ts, we, wa, wd);
      else step(wv, w[0], w[1], w[2], w[3], 0, 0, tr, oa, es, ts, we, wa, wd);
    end
    check_outs();
  endtask

  initial begin
    int ones;
    model_reset();
    do_reset();

    // Positive saturation, deterministic spike.
    blk(3, 0, 100, 0, 1, 0);
    chk("s1_spike", spike, 1);

    // Negative saturation, stochastic spike never fires.
    for (int r = 0; r < 3; r++) begin
      blk(4, 0, -256, 1, 1, 0);
      chk("sat_spike", spike, 0);
    end

    // Directed feedback: fb[3] = -20, five error hits, true hits out of range.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 3, -20);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    check_outs();
    chk("fb_err", $signed(err), -100);
    chk("fb_true", $signed(true), 0);
    // Same-cycle write/read of one index returns the old value.
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 1, 3, 7);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("fb_rdw_err", $signed(err), -13);

    // Delay line fill and hold on an untrained block.
    do_reset();
    for (int b = 1; b <= 4; b++) begin
      blk(1, 3, 10 * b, 1, 0, 0);
      if (b == 3) chk("fpv_b3", fp_valid, 0);
    end
    chk("fpv_b4", fp_valid, 1);
    chk("fp_b4", $signed(fp), 10);
    blk(1, 3, 77, 0, 0, 0);
    chk("fp_hold", $signed(fp), 10);
    blk(1, 3, 50, 1, 0, 0);
    chk("fp_b5", $signed(fp), 20);

    // Reset in the middle of a block, then the first scenario again.
    for (int c = 0; c < 3; c++) step(1, 100, 100, 100, 100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    do_reset();
    blk(3, 0, 100, 0, 1, 0);
    chk("s6_spike", spike, 1);

    // Random blocks.
    for (int b = 0; b < 150; b++)
      blk($urandom_range(1, 6), $urandom_range(1, 2), 0, $urandom_range(0, 1),
          $urandom_range(0, 1), 1);

    // Stochastic rate with internal held at 0.
    do_reset();
    ones = 0;
    for (int b = 0; b < 4096; b++) begin
      step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("stoch_spike", spike, int'(m_spike));
      ones += int'(spike);
    end
    chk("stoch_rate", int'(ones >= 1925 && ones <= 2171), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
